// File: rtl/fib_seq_gen.sv
// Fibonacci-style sequence generator: two seeds, valid/ready output stream,
// stops on value threshold, term count, or imminent overflow of the next term.
module fib_seq_gen #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic [WIDTH-1:0] limit,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] term_count,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CMP_W = (WIDTH > CNT_W) ? WIDTH : CNT_W;

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] lim;
  logic             md;
  logic             b_ovf;

  logic [CNT_W-1:0] cnt_next;
  logic [CMP_W-1:0] cnt_ext;
  logic [CMP_W-1:0] lim_ext;
  logic [WIDTH:0]   sum;
  logic             last;

  always_comb begin
    cnt_next = term_count + 1'b1;
    cnt_ext  = CMP_W'(cnt_next);
    lim_ext  = CMP_W'(lim);
    sum      = {1'b0, a} + {1'b0, b};
    // b_ovf flags that the term after a is inexact, so a must be the final one
    last     = b_ovf || (md ? (cnt_ext == lim_ext) : (a >= lim));
  end

  assign out_valid = (state == RUN);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign out_last  = (state == RUN) && last;
  assign out_data  = a;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      a          <= '0;
      b          <= '0;
      lim        <= '0;
      md         <= 1'b0;
      b_ovf      <= 1'b0;
      term_count <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a          <= seed0;
            b          <= seed1;
            lim        <= limit;
            md         <= mode;
            b_ovf      <= 1'b0;
            term_count <= '0;
            overflow   <= 1'b0;
            state      <= (mode && (limit == '0)) ? DONE : RUN;
          end
        end
        RUN: begin
          if (out_ready) begin
            term_count <= cnt_next;
            if (last) begin
              overflow <= b_ovf;
              state    <= DONE;
            end else begin
              a     <= b;
              b     <= sum[WIDTH-1:0];
              b_ovf <= sum[WIDTH];
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_seq_gen.sv
// Scoreboarded bench for fib_seq_gen: the driver queues expected terms from an
// exact-arithmetic reference, a negedge monitor pops and compares them.
module tb_fib_seq_gen;

  localparam int W = 8;
  localparam int C = 8;

  logic         clock;
  logic         reset;
  logic         start;
  logic [W-1:0] seed0;
  logic [W-1:0] seed1;
  logic [W-1:0] limit;
  logic         mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic [C-1:0] term_count;
  logic         busy;
  logic         done;
  logic         overflow;

  fib_seq_gen #(.WIDTH(W), .CNT_W(C)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .seed0      (seed0),
    .seed1      (seed1),
    .limit      (limit),
    .mode       (mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .term_count (term_count),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } term_t;

  typedef struct packed {
    logic [C-1:0] cnt;
    logic         ovf;
  } summ_t;

  term_t exp_q[$];
  summ_t sum_q[$];
  int    total = 0;
  int    bad   = 0;
  bit    bp    = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference: true (unbounded) sequence; a term is last when the stop rule
  // holds or when the following term no longer fits in W bits.
  task automatic model(input int s0, input int s1, input int lim, input bit md,
                       output int n);
    longint cur, nxt, tmp;
    bit     last;
    term_t  t;
    summ_t  s;
    n    = 0;
    last = 1'b0;
    cur  = s0;
    nxt  = s1;
    s.ovf = 1'b0;
    if (!(md && lim == 0)) begin
      for (int i = 0; i < 400 && !last; i++) begin
        last = (!md && cur >= lim) || (md && ((n + 1) % 256) == lim) ||
               (nxt >= (longint'(1) << W));
        t.d = cur[W-1:0];
        t.l = last;
        exp_q.push_back(t);
        n++;
        if (last) s.ovf = (nxt >= (longint'(1) << W));
        tmp = cur + nxt;
        cur = nxt;
        nxt = tmp;
      end
    end
    s.cnt = C'(n % 256);
    sum_q.push_back(s);
  endtask

  // Called at posedge+1; returns at the first negedge after start was taken.
  task automatic launch(input int s0, input int s1, input int lim, input bit md);
    int n;
    model(s0, s1, lim, md, n);
    seed0 = W'(s0);
    seed1 = W'(s1);
    limit = W'(lim);
    mode  = md;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    seed0 = W'($urandom);
    seed1 = W'($urandom);
    limit = W'($urandom);
    mode  = 1'($urandom_range(0, 1));
    @(negedge clock);
    check("first_valid", out_valid, (n > 0));
    if (n > 0) check("busy_run", busy, 1);
    else check("zero_done", done, 1);
  endtask

  task automatic finish_seq();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!seen) check("done_timeout", 0, 1);
    @(posedge clock);
    #1;
    check("idle_busy", busy, 0);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    bit           stall;
    logic [W-1:0] held_d;
    logic         held_l;
    term_t        e;
    summ_t        s;
    stall = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, held_d);
          check("hold_last", out_last, held_l);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check("unexpected_term", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("term_data", out_data, e.d);
            check("term_last", out_last, e.l);
          end
          stall = 1'b0;
        end else if (out_valid) begin
          stall  = 1'b1;
          held_d = out_data;
          held_l = out_last;
        end else begin
          stall = 1'b0;
        end
        if (done) begin
          check("done_valid", out_valid, 0);
          if (sum_q.size() == 0) check("unexpected_done", 1, 0);
          else begin
            s = sum_q.pop_front();
            check("term_count", term_count, s.cnt);
            check("overflow", overflow, s.ovf);
            check("missing_terms", exp_q.size(), 0);
          end
        end
      end
    end
  end

  initial begin
    int k;
    int s0;
    int s1;
    bit md;
    reset = 1'b1;
    start = 1'b0;
    seed0 = '0;
    seed1 = '0;
    limit = '0;
    mode  = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_outputs", {out_valid, out_last, busy, done, overflow, term_count, out_data}, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    launch(0, 1, 20, 0);  finish_seq();
    launch(2, 1, 5, 1);   finish_seq();
    launch(0, 1, 20, 1);  finish_seq();
    bp = 1;
    launch(0, 1, 20, 0);  finish_seq();
    bp = 0;
    launch(5, 6, 0, 1);   finish_seq();

    // start held high for several RUN cycles must not relaunch
    launch(0, 1, 20, 0);
    @(negedge clock);
    seed0 = 8'd77;
    seed1 = 8'd3;
    start = 1'b1;
    repeat (3) @(negedge clock);
    start = 1'b0;
    finish_seq();

    // reset after the 4th transfer, then relaunch from the seeds
    launch(0, 1, 20, 0);
    k = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid && out_ready) k++;
      if (k == 4) break;
      @(negedge clock);
    end
    check("mid_transfers", k, 4);
    @(posedge clock);
    #1;
    reset = 1'b1;
    exp_q.delete();
    sum_q.delete();
    @(posedge clock);
    @(negedge clock);
    check("midreset_outputs", {out_valid, out_last, busy, done, overflow, term_count, out_data}, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    launch(0, 1, 20, 0);  finish_seq();

    for (int r = 0; r < 25; r++) begin
      bp = 1'($urandom_range(0, 1));
      md = 1'($urandom_range(0, 1));
      s0 = int'($urandom_range(0, 255));
      s1 = int'($urandom_range(0, 255));
      if (!md && s0 + s1 == 0) s1 = 1;
      launch(s0, s1, md ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 255)), md);
      finish_seq();
    end
    bp = 0;
    check("leftover_summaries", sum_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
